issueque_int: RTL and testbench

- Integer issue queue: the CDB-consumer and issue-requester end of the integer path.
- Accepts dispatched integer instructions and holds them in age order.
- Snoops the CDB to wake up pending source operands.
- Presents the oldest fully-ready entry to the issue unit via issueint_ready/operands; retires it on issueint_equeueint_done.

---
 rtl/issueque_int_pkg.sv | 30 +++
 rtl/issueque_int_if.sv | 58 +++++
 rtl/issueque_int_entry.sv | 82 ++++++++
 rtl/issueque_int.sv | 158 +++++++++++++++
 tb/tb_issueque_int.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/issueque_int_pkg.sv
// +----------------------------------------------------------------------+
// | issueque_int_pkg                                                     |
// | Shared widths, depth default, integer opcodes, slot source select.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package issueque_int_pkg;

  localparam int C_DEPTH  = 4;
  localparam int C_TAG_W  = 6;
  localparam int C_DATA_W = 32;
  localparam int C_OPC_W  = 6;

  localparam logic [C_OPC_W-1:0] C_OP_ADD = 6'h20;
  localparam logic [C_OPC_W-1:0] C_OP_SUB = 6'h22;
  localparam logic [C_OPC_W-1:0] C_OP_AND = 6'h24;
  localparam logic [C_OPC_W-1:0] C_OP_OR  = 6'h25;
  localparam logic [C_OPC_W-1:0] C_OP_SLT = 6'h2A;

  // Where a slot takes its next contents from
  typedef enum logic [1:0] {
    SRC_HOLD  = 2'd0,
    SRC_SHIFT = 2'd1,
    SRC_LOAD  = 2'd2
  } slot_src_e;

endpackage

`default_nettype wire

// File: rtl/issueque_int_if.sv
// +----------------------------------------------------------------------+
// | issueque_int_if                                                      |
// | Dispatch, CDB and issue signals of the integer issue queue.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface issueque_int_if
  import issueque_int_pkg::*;
#(
  parameter int TAG_W  = C_TAG_W,
  parameter int DATA_W = C_DATA_W,
  parameter int OPC_W  = C_OPC_W
);

  logic              dispatch_en;
  logic [OPC_W-1:0]  dispatch_opcode;
  logic [DATA_W-1:0] dispatch_rsdata;
  logic [TAG_W-1:0]  dispatch_rstag;
  logic              dispatch_rsvalid;
  logic [DATA_W-1:0] dispatch_rtdata;
  logic [TAG_W-1:0]  dispatch_rttag;
  logic              dispatch_rtvalid;
  logic [TAG_W-1:0]  dispatch_rdtag;
  logic              issueque_full;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_branch;
  logic              cdb_branch_taken;
  logic              issueint_ready;
  logic [OPC_W-1:0]  issueint_opcode;
  logic [DATA_W-1:0] issueint_rsdata;
  logic [DATA_W-1:0] issueint_rtdata;
  logic [TAG_W-1:0]  issueint_rdtag;
  logic              issueint_equeueint_done;

  modport master (
    output dispatch_en, dispatch_opcode, dispatch_rsdata, dispatch_rstag,
           dispatch_rsvalid, dispatch_rtdata, dispatch_rttag, dispatch_rtvalid,
           dispatch_rdtag, cdb_valid, cdb_tag, cdb_data, cdb_branch,
           cdb_branch_taken, issueint_equeueint_done,
    input  issueque_full, issueint_ready, issueint_opcode, issueint_rsdata,
           issueint_rtdata, issueint_rdtag
  );

  modport slave (
    input  dispatch_en, dispatch_opcode, dispatch_rsdata, dispatch_rstag,
           dispatch_rsvalid, dispatch_rtdata, dispatch_rttag, dispatch_rtvalid,
           dispatch_rdtag, cdb_valid, cdb_tag, cdb_data, cdb_branch,
           cdb_branch_taken, issueint_equeueint_done,
    output issueque_full, issueint_ready, issueint_opcode, issueint_rsdata,
           issueint_rtdata, issueint_rdtag
  );

endinterface

`default_nettype wire

// File: rtl/issueque_int_entry.sv
// +----------------------------------------------------------------------+
// | issueque_int_entry                                                   |
// | One queue slot: source mux (hold/shift/load), CDB capture, register. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module issueque_int_entry
  import issueque_int_pkg::*;
#(
  parameter  int TAG_W  = C_TAG_W,
  parameter  int DATA_W = C_DATA_W,
  parameter  int OPC_W  = C_OPC_W,
  localparam int SLOT_W = 1 + OPC_W + 2 * (DATA_W + TAG_W + 1) + TAG_W
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire slot_src_e         i_src,
  input  wire logic              i_clear,
  input  wire logic [SLOT_W-1:0] i_up,
  input  wire logic [SLOT_W-1:0] i_dsp,
  input  wire logic              i_cdb_valid,
  input  wire logic [TAG_W-1:0]  i_cdb_tag,
  input  wire logic [DATA_W-1:0] i_cdb_data,
  output logic      [SLOT_W-1:0] o_slot
);

  // Field order must match the slot_t in issueque_int
  typedef struct packed {
    logic              valid;
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] rs_data;
    logic [TAG_W-1:0]  rs_tag;
    logic              rs_rdy;
    logic [DATA_W-1:0] rt_data;
    logic [TAG_W-1:0]  rt_tag;
    logic              rt_rdy;
    logic [TAG_W-1:0]  rd_tag;
  } slot_t;

  slot_t r_slot;
  slot_t w_src;
  slot_t w_next;
  logic  w_rs_hit;
  logic  w_rt_hit;

  // Wakeup is applied after the mux so shifted and freshly loaded contents capture too
  always_comb begin
    case (i_src)
      SRC_SHIFT: w_src = slot_t'(i_up);
      SRC_LOAD:  w_src = slot_t'(i_dsp);
      default:   w_src = r_slot;
    endcase
    w_rs_hit = i_cdb_valid & w_src.valid & ~w_src.rs_rdy & (w_src.rs_tag == i_cdb_tag);
    w_rt_hit = i_cdb_valid & w_src.valid & ~w_src.rt_rdy & (w_src.rt_tag == i_cdb_tag);
    w_next   = w_src;
    if (w_rs_hit) begin
      w_next.rs_data = i_cdb_data;
      w_next.rs_rdy  = 1'b1;
    end
    if (w_rt_hit) begin
      w_next.rt_data = i_cdb_data;
      w_next.rt_rdy  = 1'b1;
    end
    if (i_clear) begin
      w_next.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot <= '0;
    end else begin
      r_slot <= w_next;
    end
  end

  assign o_slot = r_slot;

endmodule

`default_nettype wire

// File: rtl/issueque_int.sv
// +----------------------------------------------------------------------+
// | issueque_int                                                         |
// | Age-ordered integer issue queue with CDB wakeup and oldest-ready     |
// | select. Optional ISSUEQUE_BRANCH_FLUSH_EN: taken branch flushes all. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module issueque_int
  import issueque_int_pkg::*;
#(
  parameter int DEPTH  = C_DEPTH,
  parameter int TAG_W  = C_TAG_W,
  parameter int DATA_W = C_DATA_W,
  parameter int OPC_W  = C_OPC_W
) (
  input wire logic      clk,
  input wire logic      reset_n,
  issueque_int_if.slave bus
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int SLOT_W = 1 + OPC_W + 2 * (DATA_W + TAG_W + 1) + TAG_W;

  typedef struct packed {
    logic              valid;
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] rs_data;
    logic [TAG_W-1:0]  rs_tag;
    logic              rs_rdy;
    logic [DATA_W-1:0] rt_data;
    logic [TAG_W-1:0]  rt_tag;
    logic              rt_rdy;
    logic [TAG_W-1:0]  rd_tag;
  } slot_t;

  logic [SLOT_W-1:0] w_slot_vec [DEPTH];
  slot_t             w_slot     [DEPTH];
  slot_src_e         w_src      [DEPTH];
  logic [DEPTH-1:0]  w_ready_vec;
  logic [IDX_W-1:0]  w_sel_idx;
  logic              w_any;
  slot_t             w_sel;
  slot_t             w_dsp_slot;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_dsp_idx;
  logic              w_full;
  logic              w_flush;
  logic              w_retire;
  logic              w_dispatch;
  logic              w_unused_sel;

`ifdef ISSUEQUE_BRANCH_FLUSH_EN
  assign w_flush = bus.cdb_branch & bus.cdb_branch_taken;
`else
  logic w_unused_branch;
  assign w_unused_branch = bus.cdb_branch ^ bus.cdb_branch_taken;
  assign w_flush         = 1'b0;
`endif

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_retire   = bus.issueint_equeueint_done & w_any & ~w_flush;
  assign w_dispatch = bus.dispatch_en & ~w_full & ~w_flush;
  assign w_dsp_idx  = w_retire ? (r_count - CNT_W'(1)) : r_count;

  always_comb begin
    w_dsp_slot         = '0;
    w_dsp_slot.valid   = 1'b1;
    w_dsp_slot.opcode  = bus.dispatch_opcode;
    w_dsp_slot.rs_data = bus.dispatch_rsdata;
    w_dsp_slot.rs_tag  = bus.dispatch_rstag;
    w_dsp_slot.rs_rdy  = bus.dispatch_rsvalid;
    w_dsp_slot.rt_data = bus.dispatch_rtdata;
    w_dsp_slot.rt_tag  = bus.dispatch_rttag;
    w_dsp_slot.rt_rdy  = bus.dispatch_rtvalid;
    w_dsp_slot.rd_tag  = bus.dispatch_rdtag;
  end

  // Oldest ready wins: scan from the top so the lowest index is written last
  always_comb begin
    w_any     = 1'b0;
    w_sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_ready_vec[i]) begin
        w_any     = 1'b1;
        w_sel_idx = IDX_W'(i);
      end
    end
  end

  // Valid slots stay packed at the bottom, so the dispatch slot is always the first free one
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_src[i] = SRC_HOLD;
      if (w_retire && (IDX_W'(i) >= w_sel_idx)) begin
        w_src[i] = SRC_SHIFT;
      end
      if (w_dispatch && (CNT_W'(i) == w_dsp_idx)) begin
        w_src[i] = SRC_LOAD;
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [SLOT_W-1:0] w_up;
    if (gi == DEPTH - 1) begin : g_top
      assign w_up = '0;
    end else begin : g_mid
      assign w_up = w_slot_vec[gi+1];
    end

    issueque_int_entry #(
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W),
      .OPC_W  (OPC_W)
    ) u_entry (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_src       (w_src[gi]),
      .i_clear     (w_flush),
      .i_up        (w_up),
      .i_dsp       (w_dsp_slot),
      .i_cdb_valid (bus.cdb_valid),
      .i_cdb_tag   (bus.cdb_tag),
      .i_cdb_data  (bus.cdb_data),
      .o_slot      (w_slot_vec[gi])
    );

    assign w_slot[gi]      = slot_t'(w_slot_vec[gi]);
    assign w_ready_vec[gi] = w_slot[gi].valid & w_slot[gi].rs_rdy & w_slot[gi].rt_rdy;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (w_flush) begin
      r_count <= '0;
    end else if (w_dispatch && !w_retire) begin
      r_count <= r_count + CNT_W'(1);
    end else if (!w_dispatch && w_retire) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign w_sel        = w_slot[w_sel_idx];
  assign w_unused_sel = ^{w_sel.valid, w_sel.rs_tag, w_sel.rs_rdy, w_sel.rt_tag, w_sel.rt_rdy};

  assign bus.issueque_full   = w_full;
  assign bus.issueint_ready  = w_any;
  assign bus.issueint_opcode = w_any ? w_sel.opcode  : '0;
  assign bus.issueint_rsdata = w_any ? w_sel.rs_data : '0;
  assign bus.issueint_rtdata = w_any ? w_sel.rt_data : '0;
  assign bus.issueint_rdtag  = w_any ? w_sel.rd_tag  : '0;

endmodule

`default_nettype wire

// File: tb/tb_issueque_int.sv
// +----------------------------------------------------------------------+
// | tb_issueque_int                                                      |
// | Directed scenarios plus random traffic against a queue-based model.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_issueque_int;
  import issueque_int_pkg::*;

  localparam int DEPTH = C_DEPTH;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  issueque_int_if bus ();

  issueque_int #(
    .DEPTH  (DEPTH),
    .TAG_W  (C_TAG_W),
    .DATA_W (C_DATA_W),
    .OPC_W  (C_OPC_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [C_OPC_W-1:0]  opc;
    logic [C_DATA_W-1:0] rs;
    logic [C_DATA_W-1:0] rt;
    logic [C_TAG_W-1:0]  rst;
    logic [C_TAG_W-1:0]  rtt;
    logic [C_TAG_W-1:0]  rd;
    bit                  rsr;
    bit                  rtr;
  } ment_t;

  ment_t mq[$];

  task automatic clear_inputs();
    bus.dispatch_en = 0; bus.dispatch_opcode = '0;
    bus.dispatch_rsdata = '0; bus.dispatch_rstag = '0; bus.dispatch_rsvalid = 0;
    bus.dispatch_rtdata = '0; bus.dispatch_rttag = '0; bus.dispatch_rtvalid = 0;
    bus.dispatch_rdtag = '0; bus.cdb_valid = 0; bus.cdb_tag = '0; bus.cdb_data = '0;
    bus.cdb_branch = 0; bus.cdb_branch_taken = 0; bus.issueint_equeueint_done = 0;
  endtask

  task automatic dsp(input logic [C_OPC_W-1:0] opc,
                     input logic [C_DATA_W-1:0] rs, input logic [C_TAG_W-1:0] rst, input bit rsv,
                     input logic [C_DATA_W-1:0] rt, input logic [C_TAG_W-1:0] rtt, input bit rtv,
                     input logic [C_TAG_W-1:0] rd);
    bus.dispatch_en = 1; bus.dispatch_opcode = opc;
    bus.dispatch_rsdata = rs; bus.dispatch_rstag = rst; bus.dispatch_rsvalid = rsv;
    bus.dispatch_rtdata = rt; bus.dispatch_rttag = rtt; bus.dispatch_rtvalid = rtv;
    bus.dispatch_rdtag = rd;
  endtask

  function automatic int model_sel();
    foreach (mq[i]) if (mq[i].rsr && mq[i].rtr) return i;
    return -1;
  endfunction

  // Queue semantics: wake pending operands, drop the issued entry, append the new one
  task automatic model_update();
    int    sel  = model_sel();
    bit    full = (mq.size() == DEPTH);
    bit    flush = 0;
    ment_t e;
`ifdef ISSUEQUE_BRANCH_FLUSH_EN
    flush = bus.cdb_branch && bus.cdb_branch_taken;
`endif
    if (flush) begin
      mq.delete();
      return;
    end
    if (bus.cdb_valid) begin
      foreach (mq[i]) begin
        if (!mq[i].rsr && mq[i].rst == bus.cdb_tag) begin mq[i].rs = bus.cdb_data; mq[i].rsr = 1; end
        if (!mq[i].rtr && mq[i].rtt == bus.cdb_tag) begin mq[i].rt = bus.cdb_data; mq[i].rtr = 1; end
      end
    end
    if (bus.issueint_equeueint_done && sel >= 0) mq.delete(sel);
    if (bus.dispatch_en && !full) begin
      e.opc = bus.dispatch_opcode; e.rd = bus.dispatch_rdtag;
      e.rs = bus.dispatch_rsdata; e.rst = bus.dispatch_rstag; e.rsr = bus.dispatch_rsvalid;
      e.rt = bus.dispatch_rtdata; e.rtt = bus.dispatch_rttag; e.rtr = bus.dispatch_rtvalid;
      if (!e.rsr && bus.cdb_valid && e.rst == bus.cdb_tag) begin e.rs = bus.cdb_data; e.rsr = 1; end
      if (!e.rtr && bus.cdb_valid && e.rtt == bus.cdb_tag) begin e.rt = bus.cdb_data; e.rtr = 1; end
      mq.push_back(e);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic apply_reset();
    reset_n = 0;
    clear_inputs();
    mq.delete();
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.issueque_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", bus.issueque_full); end
    checks++; if (bus.issueint_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b exp 0", bus.issueint_ready); end
    checks++; if ({bus.issueint_opcode, bus.issueint_rsdata, bus.issueint_rtdata, bus.issueint_rdtag} !== '0) begin
      errors++; $display("FAIL reset_data got op=%0h rs=%0h rt=%0h rd=%0h exp 0", bus.issueint_opcode,
                         bus.issueint_rsdata, bus.issueint_rtdata, bus.issueint_rdtag); end
    // Asynchronous reset in the middle of a cycle discards a live entry at once
    dsp(C_OP_SUB, 32'd1, 6'd0, 1, 32'd2, 6'd0, 1, 6'd9);
    step();
    #2 reset_n = 0;
    #1;
    checks++; if (bus.issueint_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready got %0b exp 0", bus.issueint_ready); end
    apply_reset();
  endtask

  task automatic test_basic();
    dsp(C_OP_ADD, 32'd5, 6'd0, 1, 32'd7, 6'd0, 1, 6'd3);
    step();
    checks++; if (bus.issueint_ready !== 1'b1 || bus.issueint_rsdata !== 32'd5 || bus.issueint_rtdata !== 32'd7 ||
                  bus.issueint_rdtag !== 6'd3 || bus.issueint_opcode !== C_OP_ADD) begin
      errors++; $display("FAIL basic_issue got rdy=%0b op=%0h rs=%0d rt=%0d rd=%0d exp 1/%0h/5/7/3", bus.issueint_ready,
                         bus.issueint_opcode, bus.issueint_rsdata, bus.issueint_rtdata, bus.issueint_rdtag, C_OP_ADD); end
    bus.issueint_equeueint_done = 1;
    step();
    checks++; if (bus.issueint_ready !== 1'b0) begin errors++; $display("FAIL basic_retire got rdy=%0b exp 0", bus.issueint_ready); end
    bus.issueint_equeueint_done = 1;  // done while empty is ignored
    step();
    checks++; if (bus.issueint_ready !== 1'b0 || bus.issueque_full !== 1'b0) begin
      errors++; $display("FAIL empty_done got rdy=%0b full=%0b exp 0/0", bus.issueint_ready, bus.issueque_full); end
  endtask

  task automatic test_cdb_wakeup();
    dsp(C_OP_OR, 32'd1, 6'd0, 1, 32'd0, 6'd9, 0, 6'd4);
    step();
    checks++; if (bus.issueint_ready !== 1'b0) begin errors++; $display("FAIL wake_pending got rdy=%0b exp 0", bus.issueint_ready); end
    // Branch-only CDB cycle without cdb_valid must not wake anything
    bus.cdb_branch = 1; bus.cdb_tag = 6'd9; bus.cdb_data = 32'hDEAD;
    step();
    checks++; if (bus.issueint_ready !== 1'b0) begin errors++; $display("FAIL wake_branch_only got rdy=%0b exp 0", bus.issueint_ready); end
    bus.cdb_valid = 1; bus.cdb_tag = 6'd9; bus.cdb_data = 32'h1234;
    step();
    checks++; if (bus.issueint_ready !== 1'b1 || bus.issueint_rtdata !== 32'h1234 || bus.issueint_rdtag !== 6'd4) begin
      errors++; $display("FAIL wake_cdb got rdy=%0b rt=%0h rd=%0d exp 1/1234/4", bus.issueint_ready,
                         bus.issueint_rtdata, bus.issueint_rdtag); end
    bus.issueint_equeueint_done = 1;
    step();
  endtask

  task automatic test_forwarding();
    dsp(C_OP_AND, 32'd0, 6'd12, 0, 32'd3, 6'd0, 1, 6'd5);
    bus.cdb_valid = 1; bus.cdb_tag = 6'd12; bus.cdb_data = 32'hAA;
    step();
    checks++; if (bus.issueint_ready !== 1'b1 || bus.issueint_rsdata !== 32'hAA) begin
      errors++; $display("FAIL forward got rdy=%0b rs=%0h exp 1/aa", bus.issueint_ready, bus.issueint_rsdata); end
    bus.issueint_equeueint_done = 1;
    step();
    checks++; if (bus.issueint_ready !== 1'b0) begin errors++; $display("FAIL forward_retire got rdy=%0b exp 0", bus.issueint_ready); end
  endtask

  task automatic test_full_drop();
    for (int k = 1; k <= DEPTH; k++) begin
      dsp(C_OP_ADD, 32'(16 + k), 6'd0, 1, 32'(k), 6'd0, 1, 6'(k));
      step();
    end
    checks++; if (bus.issueque_full !== 1'b1) begin errors++; $display("FAIL full_set got %0b exp 1", bus.issueque_full); end
    dsp(C_OP_ADD, 32'd99, 6'd0, 1, 32'd99, 6'd0, 1, 6'd5);
    bus.issueint_equeueint_done = 1;
    step();
    checks++; if (bus.issueque_full !== 1'b0) begin errors++; $display("FAIL full_drop got full=%0b exp 0", bus.issueque_full); end
    for (int k = 2; k <= DEPTH; k++) begin
      checks++; if (bus.issueint_ready !== 1'b1 || bus.issueint_rdtag !== 6'(k) || bus.issueint_rsdata !== 32'(16 + k)) begin
        errors++; $display("FAIL full_order got rdy=%0b rd=%0d rs=%0d exp 1/%0d/%0d", bus.issueint_ready,
                           bus.issueint_rdtag, bus.issueint_rsdata, k, 16 + k); end
      bus.issueint_equeueint_done = 1;
      step();
    end
    checks++; if (bus.issueint_ready !== 1'b0) begin errors++; $display("FAIL full_dropped_gone got rdy=%0b exp 0", bus.issueint_ready); end
  endtask

  task automatic test_out_of_order();
    dsp(C_OP_SLT, 32'd0, 6'd20, 0, 32'd1, 6'd0, 1, 6'd30); step();
    dsp(C_OP_ADD, 32'd2, 6'd0, 1, 32'd3, 6'd0, 1, 6'd31); step();
    dsp(C_OP_SUB, 32'd4, 6'd0, 1, 32'd0, 6'd20, 0, 6'd32); step();
    checks++; if (bus.issueint_ready !== 1'b1 || bus.issueint_rdtag !== 6'd31) begin
      errors++; $display("FAIL ooo_younger got rdy=%0b rd=%0d exp 1/31", bus.issueint_ready, bus.issueint_rdtag); end
    bus.issueint_equeueint_done = 1; bus.cdb_valid = 1; bus.cdb_tag = 6'd20; bus.cdb_data = 32'h55;
    step();
    checks++; if (bus.issueint_ready !== 1'b1 || bus.issueint_rdtag !== 6'd30 || bus.issueint_rsdata !== 32'h55) begin
      errors++; $display("FAIL ooo_older_wake got rdy=%0b rd=%0d rs=%0h exp 1/30/55", bus.issueint_ready,
                         bus.issueint_rdtag, bus.issueint_rsdata); end
    bus.issueint_equeueint_done = 1;
    step();
    checks++; if (bus.issueint_ready !== 1'b1 || bus.issueint_rdtag !== 6'd32 || bus.issueint_rtdata !== 32'h55) begin
      errors++; $display("FAIL ooo_shift_wake got rdy=%0b rd=%0d rt=%0h exp 1/32/55", bus.issueint_ready,
                         bus.issueint_rdtag, bus.issueint_rtdata); end
    bus.issueint_equeueint_done = 1;
    step();
    checks++; if (bus.issueint_ready !== 1'b0) begin errors++; $display("FAIL ooo_drain got rdy=%0b exp 0", bus.issueint_ready); end
  endtask

  task automatic test_branch();
    for (int k = 0; k < 3; k++) begin
      dsp(C_OP_ADD, 32'(k), 6'd0, 1, 32'(k), 6'd0, 1, 6'(40 + k));
      step();
    end
    bus.cdb_branch = 1; bus.cdb_branch_taken = 1; bus.issueint_equeueint_done = 1;
    dsp(C_OP_OR, 32'd7, 6'd0, 1, 32'd7, 6'd0, 1, 6'd50);
    step();
`ifdef ISSUEQUE_BRANCH_FLUSH_EN
    checks++; if (bus.issueint_ready !== 1'b0 || bus.issueque_full !== 1'b0) begin
      errors++; $display("FAIL flush got rdy=%0b full=%0b exp 0/0", bus.issueint_ready, bus.issueque_full); end
    dsp(C_OP_ADD, 32'd1, 6'd0, 1, 32'd1, 6'd0, 1, 6'd43);
    step();
    checks++; if (bus.issueint_ready !== 1'b1 || bus.issueint_rdtag !== 6'd43) begin
      errors++; $display("FAIL flush_refill got rdy=%0b rd=%0d exp 1/43", bus.issueint_ready, bus.issueint_rdtag); end
`else
    checks++; if (bus.issueint_ready !== 1'b1 || bus.issueint_rdtag !== 6'd41 || bus.issueque_full !== 1'b0) begin
      errors++; $display("FAIL noflush got rdy=%0b rd=%0d full=%0b exp 1/41/0", bus.issueint_ready,
                         bus.issueint_rdtag, bus.issueque_full); end
`endif
    apply_reset();
  endtask

  task automatic test_random();
    int          s;
    logic        exp_rdy;
    logic [C_OPC_W-1:0]  exp_opc;
    logic [C_DATA_W-1:0] exp_rs, exp_rt;
    logic [C_TAG_W-1:0]  exp_rd;
    for (int c = 0; c < 800; c++) begin
      s = model_sel();
      exp_rdy = (s >= 0);
      exp_opc = exp_rdy ? mq[s].opc : '0;
      exp_rs  = exp_rdy ? mq[s].rs  : '0;
      exp_rt  = exp_rdy ? mq[s].rt  : '0;
      exp_rd  = exp_rdy ? mq[s].rd  : '0;
      checks++; if (bus.issueint_ready !== exp_rdy || bus.issueint_opcode !== exp_opc || bus.issueint_rsdata !== exp_rs ||
                    bus.issueint_rtdata !== exp_rt || bus.issueint_rdtag !== exp_rd) begin
        errors++; $display("FAIL rand_issue cyc %0d got %0b/%0h/%0h/%0h/%0d exp %0b/%0h/%0h/%0h/%0d", c,
                           bus.issueint_ready, bus.issueint_opcode, bus.issueint_rsdata, bus.issueint_rtdata,
                           bus.issueint_rdtag, exp_rdy, exp_opc, exp_rs, exp_rt, exp_rd); end
      checks++; if (bus.issueque_full !== (mq.size() == DEPTH)) begin
        errors++; $display("FAIL rand_full cyc %0d got %0b exp %0b", c, bus.issueque_full, mq.size() == DEPTH); end
      if ($urandom_range(0, 99) < 60)
        dsp(6'($urandom_range(0, 63)), $urandom, 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $urandom, 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
      bus.cdb_valid = 1'($urandom_range(0, 1));
      bus.cdb_tag   = 6'($urandom_range(0, 7));
      bus.cdb_data  = $urandom;
      bus.issueint_equeueint_done = 1'($urandom_range(0, 1));
      bus.cdb_branch = ($urandom_range(0, 19) == 0);
      bus.cdb_branch_taken = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_basic();
    test_cdb_wakeup();
    test_forwarding();
    test_full_drop();
    test_out_of_order();
    test_branch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
